// File: rtl/stb_offset_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : stb_offset_sweep
//  Description : Calibration strobe sweeper. Re-emits the master strobe
//                delayed by a programmable offset that steps through one
//                full measured period, a configurable number of strobes per
//                offset point, under a start/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module stb_offset_sweep #(
    parameter int CNT_WIDTH  = 32,
    parameter int STEP_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stb_i,
    input  logic [CNT_WIDTH-1:0]  period_i,
    input  logic                  period_valid_i,
    input  logic                  start_i,
    input  logic [STEP_WIDTH-1:0] step_i,
    input  logic [7:0]            reps_i,
    output logic                  stb_o,
    output logic [CNT_WIDTH-1:0]  offset_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_DELAY = 2'd2
    } state_t;

    // Offset arithmetic is done one bit wider than the counters so that
    // offset + step can never wrap past the period comparison.
    localparam int c_NXT_WIDTH = CNT_WIDTH + 1;

    state_t                  r_state;
    logic                    r_stb_prev;
    logic [CNT_WIDTH-1:0]    r_per;
    logic [CNT_WIDTH-1:0]    r_offset;
    logic [CNT_WIDTH-1:0]    r_dly;
    logic [STEP_WIDTH-1:0]   r_step;
    logic [7:0]              r_reps;
    logic [7:0]              r_rep_cnt;
    logic                    r_stb;
    logic                    r_done;
    logic                    r_err;

    logic                    w_edge;
    logic                    w_start_ok;
    logic [7:0]              w_reps_eff;
    logic                    w_last_rep;
    logic [c_NXT_WIDTH-1:0]  w_nxt;
    logic                    w_sweep_end;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    assign w_edge      = stb_i & ~r_stb_prev;
    assign w_start_ok  = period_valid_i & (period_i != '0) & (step_i != '0);
    // A repetition count of zero still emits one strobe per point.
    assign w_reps_eff  = (r_reps == 8'd0) ? 8'd1 : r_reps;
    assign w_last_rep  = (r_rep_cnt >= w_reps_eff);
    assign w_nxt       = {1'b0, r_offset}
                       + {{(c_NXT_WIDTH-STEP_WIDTH){1'b0}}, r_step};
    assign w_sweep_end = (w_nxt >= {1'b0, r_per});

    // Previous strobe level for rising-edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stb_prev <= 1'b0;
        end else begin
            r_stb_prev <= stb_i;
        end
    end

    // Sweep controller: arm on an edge, count out the offset, pulse, then
    // decide in the following cycle whether to repeat, advance or finish.
    // The registered strobe doubles as the "pulse just issued" marker, which
    // is what places done_o one cycle after the final strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_per     <= '0;
            r_step    <= '0;
            r_reps    <= '0;
            r_offset  <= '0;
            r_dly     <= '0;
            r_rep_cnt <= '0;
            r_stb     <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_stb  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (w_start_ok) begin
                            r_per     <= period_i;
                            r_step    <= step_i;
                            r_reps    <= reps_i;
                            r_offset  <= '0;
                            r_rep_cnt <= '0;
                            r_err     <= 1'b0;
                            r_state   <= S_ARM;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end

                S_ARM: begin
                    if (!period_valid_i) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_edge) begin
                        r_dly   <= r_offset;
                        r_state <= S_DELAY;
                    end
                end

                S_DELAY: begin
                    if (!period_valid_i) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (r_stb) begin
                        // Cycle after the pulse: repeat, advance or finish.
                        if (!w_last_rep) begin
                            r_state <= S_ARM;
                        end else begin
                            r_rep_cnt <= '0;
                            if (w_sweep_end) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_offset <= w_nxt[CNT_WIDTH-1:0];
                                r_state  <= S_ARM;
                            end
                        end
                    end else if (r_dly == '0) begin
                        // A coincident edge is deliberately ignored here.
                        r_stb     <= 1'b1;
                        r_rep_cnt <= r_rep_cnt + 8'd1;
                    end else if (w_edge) begin
                        // New edge before the delay expired: the period has
                        // shrunk below the offset, restart from this edge.
                        r_err <= 1'b1;
                        r_dly <= r_offset;
                    end else begin
                        r_dly <= r_dly - 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // ------------------------------------------------------------------------
    assign stb_o    = r_stb;
    assign done_o   = r_done;
    assign err_o    = r_err;
    assign offset_o = r_offset;
    assign busy_o   = (r_state != S_IDLE);

endmodule
`default_nettype wire
